// File: rtl/pci_la_pkg.sv
// Shared types and helpers for the PCI logic-analyzer capture engine.
package pci_la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } la_state_e;

  function automatic int la_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/pci_la_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module pci_la_ram
  import pci_la_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = la_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Output register only loads on an accepted read, so data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pci_la_capture.sv
// Trigger-and-capture engine: circular sample buffer, masked trigger, ordered readout.
// Define LA_TRIG_EDGE_EN to fire only on a rising edge of the trigger match.
module pci_la_capture
  import pci_la_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 8
) (
  input  logic              PCI_CLK,
  input  logic              PCI_RSTn,
  input  logic [DATA_W-1:0] probe,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [ADDR_W-1:0] pre_count,
  output logic              busy,
  output logic              done,
  output logic              triggered,
  output logic [ADDR_W-1:0] trig_index,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int                DEPTH    = la_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  la_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              trig_q, trig_d;
  logic              rvld_q;

  logic              match, fire, we, re;
  logic [ADDR_W-1:0] post_init, raddr;

  assign match     = ((probe ^ val_q) & mask_q) == '0;
  assign post_init = LAST_IDX - pc_q;

`ifdef LA_TRIG_EDGE_EN
  // History is held at 0 outside WAIT, so a match already true at entry fires.
  logic mprev_q;
  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn)               mprev_q <= 1'b0;
    else if (state_q != ST_WAIT) mprev_q <= 1'b0;
    else                         mprev_q <= match;
  end
  assign fire = match & ~mprev_q;
`else
  assign fire = match;
`endif

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    fill_d  = fill_q;
    post_d  = post_q;
    tp_d    = tp_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    val_d   = val_q;
    trig_d  = trig_q;
    we      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          mask_d  = trig_mask;
          val_d   = trig_value;
          pc_d    = pre_count;
          wp_d    = '0;
          fill_d  = '0;
          trig_d  = 1'b0;
          state_d = (pre_count == '0) ? ST_WAIT : ST_FILL;
        end
      end
      ST_FILL: begin
        we     = 1'b1;
        wp_d   = wp_q + ONE;
        fill_d = fill_q + ONE;
        if (fill_q + ONE == pc_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        we   = 1'b1;
        wp_d = wp_q + ONE;
        if (fire) begin
          tp_d    = wp_q;
          trig_d  = 1'b1;
          post_d  = post_init;
          state_d = (post_init == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        we     = 1'b1;
        wp_d   = wp_q + ONE;
        post_d = post_q - ONE;
        if (post_q == ONE) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      trig_d  = 1'b0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      fill_q  <= '0;
      post_q  <= '0;
      tp_q    <= '0;
      pc_q    <= '0;
      mask_q  <= '0;
      val_q   <= '0;
      trig_q  <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      fill_q  <= fill_d;
      post_q  <= post_d;
      tp_q    <= tp_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      val_q   <= val_d;
      trig_q  <= trig_d;
      rvld_q  <= re;
    end
  end

  // Logical index 0 is the oldest of the pc pre-trigger samples.
  assign re    = rd_en & (state_q == ST_DONE);
  assign raddr = tp_q - pc_q + rd_addr;

  pci_la_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (PCI_CLK),
    .rst_n(PCI_RSTn),
    .we   (we),
    .waddr(wp_q),
    .wdata(probe),
    .re   (re),
    .raddr(raddr),
    .rdata(rd_data)
  );

  assign busy       = (state_q == ST_FILL) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign done       = (state_q == ST_DONE);
  assign triggered  = trig_q;
  assign trig_index = pc_q;
  assign rd_valid   = rvld_q;

endmodule

// File: tb/tb_pci_la_capture.sv
// Directed bench for pci_la_capture at DATA_W=8, ADDR_W=4 (16-deep buffer).
module tb_pci_la_capture;

  logic       PCI_CLK = 1'b0;
  logic       PCI_RSTn = 1'b0;
  logic [7:0] probe = '0;
  logic       arm = 1'b0, abort = 1'b0;
  logic [7:0] trig_mask = '0, trig_value = '0;
  logic [3:0] pre_count = '0;
  logic       busy, done, triggered;
  logic [3:0] trig_index;
  logic       rd_en = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;

  int n_cmp = 0, n_bad = 0;
  bit auto_inc = 1'b0;

  pci_la_capture #(.DATA_W(8), .ADDR_W(4)) dut (
    .PCI_CLK(PCI_CLK), .PCI_RSTn(PCI_RSTn), .probe(probe), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .pre_count(pre_count),
    .busy(busy), .done(done), .triggered(triggered), .trig_index(trig_index),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 PCI_CLK = ~PCI_CLK;

  typedef struct {
    logic [3:0] pre;
    logic [7:0] mask, val, start, first;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; outputs settle and are sampled 1ns after the edge.
  task automatic step();
    @(posedge PCI_CLK);
    #1;
    if (auto_inc) probe = probe + 8'd1;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 300 && !done; n++) step();
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic read_all(input logic [7:0] first, input string tag);
    logic [7:0] e;
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      step();
      e = first + 8'(i);
      chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd1);
      chk({tag, "_rd_data"}, {24'd0, rd_data}, {24'd0, e});
    end
    rd_en = 1'b0;
    step();
    chk({tag, "_rd_idle_valid"}, {31'd0, rd_valid}, 32'd0);
    e = first + 8'd15;
    chk({tag, "_rd_hold"}, {24'd0, rd_data}, {24'd0, e});
  endtask

  // Counting probe from v.start; arm inputs scrambled after arm to prove latching.
  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] last;
    probe = v.start; trig_mask = v.mask; trig_value = v.val; pre_count = v.pre;
    auto_inc = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig_mask = ~v.mask; trig_value = ~v.val; pre_count = v.pre + 4'd3;
    chk({tag, "_busy_after_arm"}, {31'd0, busy}, 32'd1);
    wait_done();
    auto_inc = 1'b0;
    last = probe - 8'd1;
    chk({tag, "_last_sample_at_done"}, {24'd0, last}, {24'd0, v.first + 8'd15});
    chk({tag, "_triggered"}, {31'd0, triggered}, 32'd1);
    chk({tag, "_trig_index"}, {28'd0, trig_index}, {28'd0, v.pre});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    read_all(v.first, tag);
  endtask

  // Hand-fed probe sequence; trigger expected on write tstep (0-based after arm).
  task automatic run_manual(input logic [3:0] pre, input logic [7:0] mask, input logic [7:0] val,
                            input logic [7:0] arm_probe, input logic [7:0] vals [20],
                            input int tstep, input string tag);
    int nwr;
    nwr = tstep + 16 - int'(pre);
    auto_inc = 1'b0;
    probe = arm_probe; trig_mask = mask; trig_value = val; pre_count = pre;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < nwr; k++) begin
      probe = vals[k];
      step();
      if (k == tstep - 1) chk({tag, "_no_trig_before"}, {31'd0, triggered}, 32'd0);
      if (k == tstep)     chk({tag, "_trig_at_step"}, {31'd0, triggered}, 32'd1);
      if (k == nwr - 2)   chk({tag, "_not_done_early"}, {31'd0, done}, 32'd0);
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      step();
      chk({tag, "_rd_data"}, {24'd0, rd_data}, {24'd0, vals[tstep - int'(pre) + i]});
    end
    rd_en = 1'b0;
  endtask

  initial begin
    vec_t tbl [5];
    logic [7:0] s6a [20];
    logic [7:0] s6b [20];
    logic [7:0] held;
    bit seen;

    tbl[0] = '{pre: 4'd4,  mask: 8'hFF, val: 8'h20, start: 8'h00, first: 8'h1C};
    tbl[1] = '{pre: 4'd0,  mask: 8'h00, val: 8'h5A, start: 8'h80, first: 8'h81};
    tbl[2] = '{pre: 4'd15, mask: 8'hFF, val: 8'h40, start: 8'h00, first: 8'h31};
    tbl[3] = '{pre: 4'd2,  mask: 8'h0F, val: 8'h05, start: 8'h30, first: 8'h33};
    tbl[4] = '{pre: 4'd7,  mask: 8'hF0, val: 8'hA0, start: 8'h90, first: 8'h99};

    s6a = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h05, 8'h56, 8'h57, 8'h08, 8'h59, 8'h5A,
            8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00};
    s6b = '{8'h01, 8'h02, 8'h03, 8'h54, 8'h55, 8'h56, 8'h07, 8'h58, 8'h09, 8'h0A,
            8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00};

    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_triggered", {31'd0, triggered}, 32'd0);
    chk("reset_trig_index", {28'd0, trig_index}, 32'd0);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
    step();
    PCI_RSTn = 1'b1;
    step();

    for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Reads outside DONE are rejected and leave rd_data untouched.
    held = rd_data;
    probe = 8'h00; trig_mask = 8'hFF; trig_value = 8'hEE; pre_count = 4'd0;
    auto_inc = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("wait_rd_hold", {24'd0, rd_data}, {24'd0, held});
    end
    rd_en = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_wait_busy", {31'd0, busy}, 32'd0);

    // Abort together with arm mid-POST.
    probe = 8'h00; trig_mask = 8'hFF; trig_value = 8'h20; pre_count = 4'd4;
    arm = 1'b1;
    step();
    arm = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      step();
      seen = triggered;
    end
    chk("abort_seq_triggered", {31'd0, triggered}, 32'd1);
    step(); step();
    chk("abort_seq_in_post", {31'd0, busy}, 32'd1);
    abort = 1'b1; arm = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_triggered", {31'd0, triggered}, 32'd0);
    step(); step();
    chk("abort_stays_idle", {31'd0, busy | done}, 32'd0);
    auto_inc = 1'b0;
    run_vec(tbl[0], "rearm");

    run_manual(4'd3, 8'hF0, 8'h50, 8'h50, s6a, 3, "held_match");
    run_manual(4'd2, 8'hF0, 8'h50, 8'h00, s6b, 3, "rise_after_low");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pci_la_capture.md
Name: pci_la_capture

Overview:
Parametrised trigger-and-capture engine for the PCI logic analyzer, successor to the fixed 48-bit/256-deep acquisition path.
- Continuously samples a DATA_W-wide probe bus into a circular buffer.
- Fires on a masked-value trigger and keeps a programmable number of pre-trigger samples.
- Freezes on completion and exposes a logically ordered read port (index 0 = oldest sample) to the readout/host logic.
- Sits between the probe mux (PCI pins) and the USB/PCI readout logic, all in the PCI_CLK domain.

Parameters:
- DATA_W, 48: probe width in bits.
- ADDR_W, 8: buffer address width; DEPTH = 2**ADDR_W samples.

Ports:
- PCI_CLK, input, 1: sole clock.
- PCI_RSTn, input, 1: asynchronous, active-low reset.
- probe, input, DATA_W: sampled every cycle.
- arm, input, 1: pulse; starts a capture from IDLE or DONE.
- abort, input, 1: pulse; returns to IDLE from any state.
- trig_mask, input, DATA_W: 1 = bit participates in the trigger compare.
- trig_value, input, DATA_W: compare value.
- pre_count, input, ADDR_W: pre-trigger samples to retain (0..DEPTH-1).
- busy, output, 1: high in FILL/WAIT/POST.
- done, output, 1: high in DONE.
- triggered, output, 1: high from the trigger cycle until the next arm or abort.
- trig_index, output, ADDR_W: logical index of the trigger sample; equals the latched pre_count.
- rd_en, input, 1: read strobe.
- rd_addr, input, ADDR_W: logical index, 0 = oldest sample.
- rd_data, output, DATA_W: read data.
- rd_valid, output, 1: high one cycle after a rd_en accepted in DONE.

Behaviour:
- Reset: state IDLE; all outputs 0; write pointer wp = 0; fill counter = 0.
- Arm latching: on arm, register trig_mask, trig_value and pre_count (pc). Input changes mid-capture have no effect.
- Match: match = (((probe ^ trig_value_q) & trig_mask_q) == 0). All-zero mask matches every cycle.
- Write rule: in FILL/WAIT/POST, RAM[wp] <= probe each cycle; wp <= wp + 1, wrapping modulo DEPTH.
- IDLE: no writes. arm -> FILL, with wp = 0 and fill counter = 0.
- FILL: write; fill counter += 1. When the counter reaches pc, go to WAIT. If pc == 0, go to WAIT on the arm cycle itself, so FILL is skipped. No trigger is accepted in FILL, which guarantees pc valid pre-samples.
- WAIT: write every cycle, overwriting the oldest data circularly.
  - On match: the probe written this cycle is the trigger sample; tp <= wp; triggered <= 1; post counter = DEPTH-1-pc.
  - If the post count is 0, go directly to DONE. Otherwise go to POST.
- POST: write; decrement the post counter. At 0 after the final write, go to DONE.
- Total samples stored per capture = DEPTH exactly: pc before the trigger, the trigger sample, and DEPTH-1-pc after it.
- DONE: no writes; buffer frozen. arm -> FILL (triggered cleared, new capture).
- abort: -> IDLE from any state; triggered and done cleared; buffer contents undefined.
- Precedence: abort beats arm on the same cycle. arm in FILL/WAIT/POST is ignored.
- Readout:
  - Physical address = (tp - pc + rd_addr) mod DEPTH.
  - Synchronous RAM gives 1-cycle latency: rd_data and rd_valid are registered.
  - rd_en outside DONE: rd_valid = 0 and rd_data holds its previous value.
  - Back-to-back rd_en is supported at one read per cycle.
- Widths: all pointer arithmetic is ADDR_W bits and wraps naturally. Counters are ADDR_W bits.

Optional Feature:
- Macro: LA_TRIG_EDGE_EN.
- Defined: the trigger fires only on the rising edge of match, i.e. match is 1 this cycle and was 0 on the previous sampled cycle. The match history register is cleared on entering WAIT, so a condition already true at WAIT entry fires on the first WAIT cycle.
- Undefined: level trigger, i.e. the first WAIT cycle with match = 1 fires.

Decomposition:
- Package pci_la_pkg: state encoding (IDLE, FILL, WAIT, POST, DONE) and a DEPTH-from-ADDR_W helper constant.
- Sub-module pci_la_ram: simple dual-port synchronous RAM, DATA_W x DEPTH, one write port, one registered read port, block-RAM inferable.
- Top holds the FSM, counters, trigger compare and address translation.

Test Plan:
Benches use DATA_W=8 and ADDR_W=4 (DEPTH 16) unless stated.
1. probe = cycle count from 0; arm; mask = FF, value = 0x20; pre_count = 4.
   -> done after the post samples; rd_addr 0..15 returns 0x1C..0x2B; trig_index = 4; triggered = 1.
2. pre_count = 0 and mask = 0.
   -> FILL is skipped and the trigger fires on the first WAIT cycle. rd_addr 0 returns the trigger sample, and 15 post samples follow contiguously.
3. pre_count = 15; trigger at probe = 0x40 after more than 40 wait cycles, forcing a wrap.
   -> rd_addr 0..15 returns 0x31..0x40; done on the trigger cycle itself, so post count = 0.
4. abort mid-POST, with arm pulsed on the same cycle.
   -> state IDLE; busy = 0, done = 0, triggered = 0. A later arm starts a fresh capture that matches scenario 1.
5. rd_en in WAIT -> rd_valid stays 0. rd_en in DONE on consecutive cycles -> rd_valid high for each request with 1-cycle latency, and the data matches the expected order.
6. With LA_TRIG_EDGE_EN: match held high through FILL, WAIT entry, then low, then high again.
   -> trigger on the first WAIT cycle only. Without the macro -> same result. A further check holds match high for 3 WAIT cycles after a low.
   -> edge mode fires once at the rising cycle.
